// File: rtl/mips_pkg.sv
// Shared encodings for the immediate extension path between decode and execute.
package mips_pkg;

  typedef logic [1:0] ext_mode_t;

  localparam ext_mode_t EXT_ZERO   = 2'd0;
  localparam ext_mode_t EXT_SIGN   = 2'd1;
  localparam ext_mode_t EXT_LUI    = 2'd2;
  localparam ext_mode_t EXT_BRANCH = 2'd3;

  localparam int EXT_MODE_W = 2;

endpackage

// File: rtl/imm_extend_pipe_slice.sv
// One valid/ready register stage with synchronous flush; the payload is only
// rewritten when a new item is actually loaded.
module pipe_slice #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_adv;

  assign w_adv   = !r_valid || i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Flush drops the valid only; the last payload stays visible on o_data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage pipelined immediate extender: S1 captures {mode, imm}, the
// extension is computed between the stages and S2 holds {mode, result}.
module imm_extend_pipe
  import mips_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [IN_W-1:0]  i_data,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic [1:0]       o_mode,
  output logic             o_busy
);

  localparam int S1_W  = IN_W + EXT_MODE_W;
  localparam int S2_W  = OUT_W + EXT_MODE_W;
  localparam int EXT_W = OUT_W - IN_W;

  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_extend_pipe: IN_W must be at least 2");
  end
  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
  end

  logic             w_s1_valid;
  logic [S1_W-1:0]  w_s1_data;
  logic             w_s2_ready;
  logic             w_s2_valid;
  logic [S2_W-1:0]  w_s2_data;

  ext_mode_t        w_mode;
  logic [IN_W-1:0]  w_imm;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;

  pipe_slice #(.W(S1_W)) u_s1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  ({i_mode, i_data}),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_data)
  );

  assign w_mode = ext_mode_t'(w_s1_data[S1_W-1 -: EXT_MODE_W]);
  assign w_imm  = w_s1_data[IN_W-1:0];
  assign w_sext = {{EXT_W{w_imm[IN_W-1]}}, w_imm};

  // OUT_W >= IN_W+2 guarantees the branch shift never loses a significant bit.
  always_comb begin
    w_ext = '0;
    case (w_mode)
      EXT_ZERO:   w_ext = {{EXT_W{1'b0}}, w_imm};
      EXT_SIGN:   w_ext = w_sext;
      EXT_LUI:    w_ext = {w_imm, {EXT_W{1'b0}}};
      EXT_BRANCH: w_ext = w_sext << 2;
      default:    w_ext = '0;
    endcase
  end

  pipe_slice #(.W(S2_W)) u_s2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  ({w_mode, w_ext}),
    .o_valid (w_s2_valid),
    .i_ready (i_ready),
    .o_data  (w_s2_data)
  );

  assign o_valid = w_s2_valid;
  assign o_mode  = w_s2_data[S2_W-1 -: EXT_MODE_W];
  assign o_data  = w_s2_data[OUT_W-1:0];
  assign o_busy  = w_s1_valid | w_s2_valid;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed and randomised checks for imm_extend_pipe with a scoreboard on the
// output handshake.
module tb_imm_extend_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_data;
  logic [1:0]  i_mode;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [1:0]  o_mode;
  logic        o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_mode  (i_mode),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_mode  (o_mode),
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] d);
    int sx;
    sx = int'($signed(d));
    case (m)
      2'd0:    return 32'(d);
      2'd1:    return 32'(sx);
      2'd2:    return {d, 16'h0000};
      default: return 32'(sx * 4);
    endcase
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard: the queue mirrors what the pipeline should currently hold.
  logic [31:0] exp_q[$];
  int          out_count = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = '0;

  always @(negedge i_clk) begin
    if (i_rst || i_flush) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(o_valid), 64'(1));
        check("hold_data", 64'(o_data), 64'(hold_data));
      end
      if (o_valid && i_ready) begin
        check("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          check("sb_data", 64'(o_data), 64'(exp_q.pop_front()));
        end
        out_count++;
        $display("OUT data=0x%08h mode=%0d", o_data, o_mode);
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(model(i_mode, i_data));
      end
      hold_prev = o_valid && !i_ready;
      hold_data = o_data;
    end
  end

  task automatic single(input logic [1:0] m, input logic [15:0] d, input logic [31:0] exp, input string tag);
    i_valid = 1'b1;
    i_mode  = m;
    i_data  = d;
    tick();
    i_valid = 1'b0;
    tick();
    check({tag, "_valid"}, 64'(o_valid), 64'(1));
    check(tag, 64'(o_data), 64'(exp));
    tick();
  endtask

  logic [1:0]  bm [4];
  logic [15:0] bd [4];
  int          idx;
  int          base;
  logic        acc;
  int          sent;
  int          cycles;
  logic        have;

  initial begin
    i_rst   = 1'b1;
    i_flush = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    i_mode  = '0;
    #1;
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_data", 64'(o_data), 64'(0));
    check("rst_mode", 64'(o_mode), 64'(0));
    check("rst_ready", 64'(o_ready), 64'(1));
    tick();
    tick();
    i_rst   = 1'b0;
    i_ready = 1'b1;

    // Back-to-back sign-extend stream: result appears one edge after S1 capture.
    i_valid = 1'b1; i_mode = 2'd1; i_data = 16'h0002;
    tick();
    check("lat_s1_only", 64'(o_valid), 64'(0));
    i_data = 16'hFFFF;
    tick();
    check("str0_valid", 64'(o_valid), 64'(1));
    check("str0_data", 64'(o_data), 64'h0000_0002);
    check("str0_mode", 64'(o_mode), 64'(1));
    i_data = 16'hFFCE;
    tick();
    check("str1_data", 64'(o_data), 64'hFFFF_FFFF);
    i_valid = 1'b0;
    tick();
    check("str2_data", 64'(o_data), 64'hFFFF_FFCE);
    tick();
    check("str_idle_valid", 64'(o_valid), 64'(0));
    check("str_idle_busy", 64'(o_busy), 64'(0));

    single(2'd0, 16'hFFCE, 32'h0000_FFCE, "zero_ffce");
    single(2'd2, 16'h1234, 32'h1234_0000, "lui_1234");
    single(2'd3, 16'hFFF0, 32'hFFFF_FFC0, "br_fff0");
    single(2'd3, 16'h0014, 32'h0000_0050, "br_0014");
    single(2'd1, 16'h8000, 32'hFFFF_8000, "sign_8000");

    // Back-pressure: only two items fit while the consumer is stalled.
    bm[0] = 2'd3; bd[0] = 16'hFFF0;
    bm[1] = 2'd0; bd[1] = 16'hFFCE;
    bm[2] = 2'd1; bd[2] = 16'h8000;
    bm[3] = 2'd2; bd[3] = 16'h00FF;
    base = out_count;
    idx = 0;
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1; i_mode = bm[idx]; i_data = bd[idx];
      #1;
      acc = o_ready;
      tick();
      if (acc && idx < 3) idx++;
    end
    check("bp_accepted", 64'(idx), 64'(2));
    check("bp_ready_low", 64'(o_ready), 64'(0));
    i_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) begin
        i_valid = 1'b1; i_mode = bm[idx]; i_data = bd[idx];
      end else begin
        i_valid = 1'b0;
      end
      #1;
      acc = i_valid && o_ready;
      tick();
      if (acc) idx++;
      if (idx == 4 && !o_busy) break;
    end
    check("bp_all_accepted", 64'(idx), 64'(4));
    check("bp_out_count", 64'(out_count - base), 64'(4));

    // Asynchronous reset with both stages loaded.
    i_ready = 1'b0;
    i_valid = 1'b1; i_mode = 2'd2; i_data = 16'h1234;
    tick();
    i_mode = 2'd0; i_data = 16'hABCD;
    tick();
    i_valid = 1'b0;
    check("mrst_pre_data", 64'(o_data), 64'h1234_0000);
    check("mrst_pre_busy", 64'(o_busy), 64'(1));
    #1;
    i_rst = 1'b1;
    #1;
    check("mrst_valid", 64'(o_valid), 64'(0));
    check("mrst_busy", 64'(o_busy), 64'(0));
    check("mrst_data", 64'(o_data), 64'(0));
    check("mrst_ready", 64'(o_ready), 64'(1));
    tick();
    i_rst = 1'b0;

    // Flush with both stages full and a new item offered.
    i_valid = 1'b1; i_mode = 2'd1; i_data = 16'h0007;
    tick();
    i_data = 16'h0008;
    tick();
    i_data = 16'h0009;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("fl_valid", 64'(o_valid), 64'(0));
    check("fl_busy", 64'(o_busy), 64'(0));
    check("fl_data_kept", 64'(o_data), 64'h0000_0007);
    base = out_count;
    i_ready = 1'b1;
    single(2'd1, 16'h0042, 32'h0000_0042, "post_flush");
    check("fl_out_count", 64'(out_count - base), 64'(1));

    // Random valid/ready traffic against the scoreboard.
    base = out_count;
    sent = 0;
    cycles = 0;
    have = 1'b0;
    while (sent < 1000 && cycles < 20000) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1'b1;
        i_mode = 2'($urandom_range(0, 3));
        i_data = 16'($urandom);
      end
      i_valid = have;
      i_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = have && o_ready;
      tick();
      cycles++;
      if (acc) begin
        have = 1'b0;
        sent++;
      end
    end
    check("rand_sent", 64'(sent), 64'(1000));
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!o_busy) break;
      tick();
    end
    check("rand_drained", 64'(o_busy), 64'(0));
    check("rand_sb_empty", 64'(exp_q.size()), 64'(0));
    check("rand_out_count", 64'(out_count - base), 64'(1000));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined successor to the core's combinational sign extender.
- Takes an IN_W-bit immediate plus a 2-bit extension mode and produces an OUT_W-bit operand.
- Modes: zero-extend, sign-extend, upper-load (LUI), branch offset (sign-extend then shift left by 2).
- Sits between decode and the execute operand mux, with a valid/ready handshake on both sides, so decode stalls and execute back-pressure are absorbed without losing immediates.

Parameters:
- IN_W, 16, immediate width in bits; must be at least 2.
- OUT_W, 32, result width in bits; must be at least IN_W+2, otherwise elaboration fails.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_flush  input  1  synchronous flush of both pipeline stages.
- i_valid  input  1  upstream presents an immediate.
- o_ready  output  1  block can accept this cycle.
- i_data  input  IN_W  immediate.
- i_mode  input  2  extension mode: 0 zero, 1 sign, 2 LUI, 3 branch.
- o_valid  output  1  o_data is valid.
- i_ready  input  1  downstream consumes this cycle.
- o_data  output  OUT_W  extended result.
- o_mode  output  2  mode that produced o_data, for debug and scoreboard.
- o_busy  output  1  either pipeline stage holds valid data.

Behaviour:
- Reset: i_rst asserted asynchronously clears s1_valid, s2_valid, o_data, o_mode and o_busy to 0. o_ready is 1 combinationally while both stages are empty. Reset mid-transfer discards all held data.
- Stages: S1 registers {i_data, i_mode}. S2 registers the computed result and the mode.
- Handshake: a transfer occurs when valid and ready are both high at the rising edge. Valid with its data is held stable until accepted; that is an upstream obligation, which the bench must also check on the output side.
- Advance rules:
  - s2_adv = !s2_valid || i_ready.
  - s1_adv = !s1_valid || s2_adv.
  - o_ready = s1_adv. This is a combinational path from i_ready to o_ready and is accepted.
- Latency: 2 cycles. Data accepted at edge k is visible on o_data / o_valid after edge k+1.
- Throughput: 1 result per cycle while i_ready stays high.
- Stall: when i_ready is low, S2 holds. S1 fills, then o_ready drops. No data is lost and none is duplicated.
- Simultaneous events:
  - Accept and consume in the same cycle: both stages shift.
  - i_flush has priority over transfers: at the edge, both valids clear and the incoming item is dropped. o_ready still reads 1 during the flush cycle, but nothing is captured.
- Arithmetic, with d = S1 data (IN_W bits):
  - Mode 0: upper OUT_W-IN_W bits zero, followed by d.
  - Mode 1: d[IN_W-1] replicated OUT_W-IN_W times, followed by d.
  - Mode 2: d placed in the top IN_W bits, lower OUT_W-IN_W bits zero.
  - Mode 3: the sign-extended value shifted left by 2 (low two bits zero). No overflow is possible given OUT_W ≥ IN_W+2.
- o_data and o_mode change only on S2 load, reset or flush. Flush clears only the valids; o_data keeps its last value.
- o_busy = s1_valid | s2_valid.

Decomposition:
- Shared package mips_pkg: mode encodings EXT_ZERO=2'd0, EXT_SIGN=2'd1, EXT_LUI=2'd2, EXT_BRANCH=2'd3, plus a typedef for the 2-bit ext_mode_t.
- Natural sub-module: pipe_slice, a parametrised data-width valid/ready register stage with flush and asynchronous reset, instantiated twice. The extension function is a combinational block between the two instances.

Test Plan (defaults IN_W=16, OUT_W=32):
- Reset with i_rst high mid-stream, S1/S2 full → o_valid=0, o_busy=0, o_data=0 immediately, without waiting for a clock edge; o_ready=1.
- i_ready=1 stream, i_mode=1: 0x0002, 0xFFFF, 0xFFCE → o_data 0x00000002, 0xFFFFFFFF, 0xFFFFFFCE on consecutive cycles, first result 2 cycles after acceptance.
- i_mode=0 with 0xFFCE → 0x0000FFCE. i_mode=2 with 0x1234 → 0x12340000. i_mode=3 with 0xFFF0 → 0xFFFFFFC0. i_mode=3 with 0x0014 → 0x00000050.
- Back-pressure: i_ready held low 5 cycles while 4 items are offered → exactly 2 accepted and o_ready=0 thereafter. After release, the items emerge in order, none dropped or duplicated, and the remaining 2 are then accepted.
- i_flush with both stages full and i_valid=1 → next cycle o_valid=0, o_busy=0; the flushed items never appear at the output.
- Random valid/ready toggling, 1000 items, all 4 modes → scoreboard matches a reference model; o_data is stable while o_valid=1 and i_ready=0.
